// File: rtl/out_channel_pkg.sv
// Shared types and constants for the program out-channel UART drain.
// Each word leaves as two 8N1 frames: the low byte, then the high bits zero-extended.
package out_channel_pkg;

  localparam int MemoryElementWidth = 12;
  localparam int BITS_PER_BYTE      = 8;
  localparam int BYTES_PER_WORD     = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/out_channel_fifo.sv
// Word FIFO. head is valid whenever count is non-zero. A push while full is dropped
// unless a pop happens on the same edge. Push and pop on one edge leave count unchanged.
module out_channel_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/out_channel_uart_tx.sv
// Buffers out-channel words and sends each as two 8N1 bytes, low byte first. A word written
// into an empty idle block is popped the next edge; a write to a full FIFO is dropped (sticky overflow).
module out_channel_uart_tx
  import out_channel_pkg::*;
#(
  parameter int WIDTH        = MemoryElementWidth,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             out_valid,
  input  logic [WIDTH-1:0] out_data,
  output logic             out_full,
  output logic             overflow,
  output logic             tx,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int              TW         = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BIT_LAST   = 3'(BITS_PER_BYTE - 1);
  localparam logic            BYTE_LAST  = 1'(BYTES_PER_WORD - 1);

  uart_state_t             state;
  logic [TW-1:0]           timer;
  logic [2:0]              bit_idx;
  logic                    byte_idx;
  logic [WIDTH-1:0]        shreg;
  logic [WIDTH-1:0]        head;
  logic [$clog2(DEPTH):0]  count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;
  logic                    bit_end;
  logic [15:0]             shreg_wide;
  logic [7:0]              cur_byte;

  out_channel_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (out_valid),
    .push_data (out_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bit_end    = (timer == TIMER_LAST);
  assign shreg_wide = 16'(shreg);
  assign cur_byte   = byte_idx ? shreg_wide[15:8] : shreg_wide[7:0];

  // The next word is taken either from idle or at the end of the last stop bit of a word,
  // so back-to-back words run with no idle gap.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (state == STOP && bit_end && byte_idx == BYTE_LAST));

  assign out_full = fifo_full;
  assign busy     = (count != '0) || (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      byte_idx   <= 1'b0;
      shreg      <= '0;
      tx         <= 1'b1;
      overflow   <= 1'b0;
      words_sent <= '0;
    end else begin
      if (out_valid && fifo_full && !pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg    <= head;
            byte_idx <= 1'b0;
            timer    <= '0;
            state    <= START;
            tx       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= cur_byte[0];
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (byte_idx != BYTE_LAST) begin
              byte_idx <= 1'b1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              words_sent <= words_sent + 16'd1;
              if (!fifo_empty) begin
                shreg    <= head;
                byte_idx <= 1'b0;
                state    <= START;
                tx       <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
